bist_response_analyzer: RTL and testbench

BIST_RESPONSE_ANALYZER -- requirements
Module: bist_response_analyzer

---
 rtl/bist_response_analyzer_pkg.sv | 19 +
 rtl/bist_response_analyzer_misr.sv | 30 +++
 rtl/bist_response_analyzer.sv | 114 +++++++++++
 tb/tb_bist_response_analyzer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_response_analyzer_pkg.sv
// bist_response_analyzer_pkg: BIST state encodings, default run length and polynomial shared with the controller.
package bist_response_analyzer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEEDED   = 3'd1,
        COMPRESS = 3'd2,
        CHECK    = 3'd3,
        DONE     = 3'd4
    } bist_state_e;

    localparam int          NCLOCK_DEFAULT = 650;
    localparam logic [15:0] POLY_DEFAULT   = 16'h8016;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bist_response_analyzer_misr.sv
// misr: multiple-input signature register, shift-left with POLY feedback folded with the parallel input.
module misr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = '0,
    parameter logic [WIDTH-1:0] SEED  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = load   ? SEED :
                enable ? ({sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data_in) :
                         sig_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sig_q <= SEED;
        else       sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer: compresses CUT responses into a MISR during a BIST run and
// grades signature, run length and toggle count at finish.
module bist_response_analyzer
    import bist_response_analyzer_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter int               NCLOCK = NCLOCK_DEFAULT,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(POLY_DEFAULT),
    parameter logic [WIDTH-1:0] SEED   = '0,
    parameter logic [WIDTH-1:0] GOLDEN = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             running,
    input  logic             toggle,
    input  logic             finish,
    input  logic [WIDTH-1:0] cut_out,
    output logic [WIDTH-1:0] signature,
    output logic [15:0]      run_count,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             proto_err
);

    localparam logic [15:0] EXP_RUNS    = 16'(NCLOCK + 1);
    localparam logic [15:0] EXP_TOGGLES = 16'((NCLOCK + 1) / 2);

    bist_state_e state_q, state_d;
    logic [15:0] run_count_q, run_count_d;
    logic [15:0] tog_q, tog_d;
    logic        done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic        proto_err_q, proto_err_d;
    logic        load, step, active, match;

    assign active = (state_q == SEEDED) || (state_q == COMPRESS);
    assign load   = init;
    assign step   = !init && active && running;

    // A saturated counter can never equal its expected value, but is excluded explicitly for robustness.
    assign match = (signature == GOLDEN) && (run_count_q == EXP_RUNS) && (tog_q == EXP_TOGGLES) &&
                   (run_count_q != 16'hFFFF) && (tog_q != 16'hFFFF);

    misr #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_misr (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .enable  (step),
        .data_in (cut_out),
        .sig     (signature)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (init)
            state_d = SEEDED;
        else
            case (state_q)
                SEEDED, COMPRESS: state_d = finish ? CHECK : (running ? COMPRESS : state_q);
                CHECK:            state_d = DONE;
                IDLE, DONE:       state_d = state_q;
                default:          state_d = IDLE;
            endcase
    end

    // Verdict is graded from the values held in DONE, so done rises two edges after finish.
    always_comb begin
        run_count_d = step ? sat_inc(run_count_q) : run_count_q;
        tog_d       = (step && toggle) ? sat_inc(tog_q) : tog_q;
        done_d      = (state_q == DONE);
        pass_d      = (state_q == DONE) && match;
        fail_d      = (state_q == DONE) && !match;
        proto_err_d = proto_err_q ||
                      (!init && (((state_q == IDLE) && (running || finish)) || ((state_q == DONE) && finish)));
        if (init) begin
            run_count_d = '0;
            tog_d       = '0;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            fail_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_count_q <= '0;
            tog_q       <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            run_count_q <= run_count_d;
            tog_q       <= tog_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign run_count = run_count_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb_bist_response_analyzer: directed scenarios with hand-computed verdicts for an 8-bit, NCLOCK=10 analyzer.
module tb_bist_response_analyzer;

    logic       clk = 1'b0;
    logic       reset, init, running, toggle, finish;
    logic [7:0] cut_out;
    logic [7:0] signature;
    logic [15:0] run_count;
    logic       done, pass, fail, proto_err;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    bist_response_analyzer #(
        .WIDTH(8), .NCLOCK(10), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .init(init), .running(running), .toggle(toggle),
        .finish(finish), .cut_out(cut_out), .signature(signature), .run_count(run_count),
        .done(done), .pass(pass), .fail(fail), .proto_err(proto_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // init, n running cycles (toggle on even cycles up to ntog pulses, c1 on cycle 1),
    // optional idle gaps, then finish; returns just after the finish-sampling edge.
    task automatic run_seq(input int n, input int ntog, input logic [7:0] c1,
                           input bit gap, input bit fin_last);
        init = 1'b1;
        tick();
        init = 1'b0;
        for (int i = 1; i <= n; i++) begin
            running = 1'b1;
            toggle  = (i % 2 == 0) && (i / 2 <= ntog);
            cut_out = (i == 1) ? c1 : 8'h00;
            finish  = fin_last && (i == n);
            tick();
            if (gap && (i % 3 == 0) && (i < n)) begin
                running = 1'b0;
                toggle  = 1'b1;
                cut_out = 8'hFF;
                finish  = 1'b0;
                tick();
                tests++;
                if (run_count !== 16'(i)) begin
                    fails++;
                    $display("FAIL hold_gap_%0d: run_count=%0d expected %0d", i, run_count, i);
                end
            end
        end
        running = 1'b0;
        toggle  = 1'b0;
        cut_out = 8'h00;
        if (!fin_last) begin
            finish = 1'b1;
            tick();
        end
        finish = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; init = 1'b0; running = 1'b0; toggle = 1'b0; finish = 1'b0; cut_out = 8'h00;
        #12;
        tests++;
        if ({signature, run_count, done, pass, fail, proto_err} !== 28'h0) begin
            fails++;
            $display("FAIL reset_state: sig=%h rc=%0d d/p/f/e=%b%b%b%b expected all 0",
                     signature, run_count, done, pass, fail, proto_err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pass;
        run_seq(11, 5, 8'h00, 1'b0, 1'b0);
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL latency_e0: done=%b expected 0", done); end
        tick();
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL latency_e1: done=%b expected 0", done); end
        tick();
        tests++;
        if ({done, pass, fail} !== 3'b110) begin
            fails++; $display("FAIL pass_verdict: d/p/f=%b%b%b expected 110", done, pass, fail);
        end
        tests++;
        if (signature !== 8'h00 || run_count !== 16'd11) begin
            fails++; $display("FAIL pass_values: sig=%h rc=%0d expected 00 11", signature, run_count);
        end
    endtask

    task automatic test_init_finish;
        init = 1'b1; finish = 1'b1;
        tick();
        init = 1'b0; finish = 1'b0;
        tests++;
        if ({done, pass, fail, proto_err} !== 4'b0000 || run_count !== 16'd0) begin
            fails++;
            $display("FAIL init_finish: d/p/f/e=%b%b%b%b rc=%0d expected 0000 0",
                     done, pass, fail, proto_err, run_count);
        end
        running = 1'b1;
        tick();
        running = 1'b0;
        tick();
        tick();
        tests++;
        if (run_count !== 16'd1 || done !== 1'b0 || proto_err !== 1'b0) begin
            fails++;
            $display("FAIL init_finish_seeded: rc=%0d done=%b err=%b expected 1 0 0", run_count, done, proto_err);
        end
    endtask

    task automatic test_fail_signature;
        run_seq(11, 5, 8'h01, 1'b0, 1'b0);
        tick(); tick();
        tests++;
        if ({done, pass, fail} !== 3'b101 || signature !== 8'h74 || run_count !== 16'd11) begin
            fails++;
            $display("FAIL bad_signature: d/p/f=%b%b%b sig=%h rc=%0d expected 101 74 11",
                     done, pass, fail, signature, run_count);
        end
    endtask

    task automatic test_short_run;
        run_seq(5, 2, 8'h00, 1'b0, 1'b0);
        tick(); tick();
        tests++;
        if ({done, pass, fail} !== 3'b101 || run_count !== 16'd5) begin
            fails++;
            $display("FAIL short_run: d/p/f=%b%b%b rc=%0d expected 101 5", done, pass, fail, run_count);
        end
    endtask

    task automatic test_toggle_count;
        run_seq(11, 4, 8'h00, 1'b0, 1'b0);
        tick(); tick();
        tests++;
        if ({done, pass, fail} !== 3'b101 || signature !== 8'h00) begin
            fails++;
            $display("FAIL toggle_count: d/p/f=%b%b%b sig=%h expected 101 00", done, pass, fail, signature);
        end
    endtask

    task automatic test_hold;
        run_seq(11, 5, 8'h00, 1'b1, 1'b0);
        tick(); tick();
        tests++;
        if ({done, pass, fail} !== 3'b110 || run_count !== 16'd11) begin
            fails++;
            $display("FAIL hold_verdict: d/p/f=%b%b%b rc=%0d expected 110 11", done, pass, fail, run_count);
        end
    endtask

    task automatic test_back_to_back;
        run_seq(11, 5, 8'h00, 1'b0, 1'b1);
        tick();
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL b2b_latency: done=%b expected 0", done); end
        tick();
        tests++;
        if ({done, pass, fail} !== 3'b110 || run_count !== 16'd11) begin
            fails++;
            $display("FAIL b2b_verdict: d/p/f=%b%b%b rc=%0d expected 110 11", done, pass, fail, run_count);
        end
    endtask

    task automatic test_abort;
        init = 1'b1;
        tick();
        init = 1'b0;
        running = 1'b1; cut_out = 8'h5A;
        repeat (6) tick();
        running = 1'b0; cut_out = 8'h00;
        run_seq(11, 5, 8'h00, 1'b0, 1'b0);
        tick(); tick();
        tests++;
        if ({done, pass, fail, proto_err} !== 4'b1100 || run_count !== 16'd11) begin
            fails++;
            $display("FAIL abort_restart: d/p/f/e=%b%b%b%b rc=%0d expected 1100 11",
                     done, pass, fail, proto_err, run_count);
        end
    endtask

    task automatic test_done_ignore;
        running = 1'b1; toggle = 1'b1; cut_out = 8'hFF;
        repeat (2) tick();
        running = 1'b0; toggle = 1'b0; cut_out = 8'h00; finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
        tests++;
        if ({done, pass, fail} !== 3'b110 || signature !== 8'h00 || run_count !== 16'd11) begin
            fails++;
            $display("FAIL done_hold: d/p/f=%b%b%b sig=%h rc=%0d expected 110 00 11",
                     done, pass, fail, signature, run_count);
        end
        tests++;
        if (proto_err !== 1'b1) begin fails++; $display("FAIL done_finish_err: proto_err=%b expected 1", proto_err); end
    endtask

    task automatic test_mid_reset;
        init = 1'b1;
        tick();
        init = 1'b0;
        running = 1'b1; cut_out = 8'h01;
        repeat (6) tick();
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({signature, run_count, done, pass, fail, proto_err} !== 28'h0) begin
            fails++;
            $display("FAIL async_reset: sig=%h rc=%0d d/p/f/e=%b%b%b%b expected all 0",
                     signature, run_count, done, pass, fail, proto_err);
        end
        running = 1'b0; cut_out = 8'h00;
        #3 reset = 1'b0;
        tick();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick(); tick();
        tests++;
        if (proto_err !== 1'b1 || done !== 1'b0 || run_count !== 16'd0) begin
            fails++;
            $display("FAIL reset_then_finish: err=%b done=%b rc=%0d expected 1 0 0", proto_err, done, run_count);
        end
    endtask

    task automatic test_idle_running;
        reset = 1'b1;
        #3 reset = 1'b0;
        tick();
        running = 1'b1;
        tick();
        running = 1'b0;
        tests++;
        if (proto_err !== 1'b1 || run_count !== 16'd0) begin
            fails++; $display("FAIL idle_running: err=%b rc=%0d expected 1 0", proto_err, run_count);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_init_finish();
        test_fail_signature();
        test_short_run();
        test_toggle_count();
        test_hold();
        test_back_to_back();
        test_abort();
        test_done_ignore();
        test_mid_reset();
        test_idle_running();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
